// File: rtl/hack_mem_responder_if.sv
// Hack CPU memory bus: CPU request/ack channel plus the program loader channel.
// The CPU (or loader) drives the master side; the memory responder is the slave.
interface hack_mem_responder_if;
  logic        ram_req;
  logic [6:0]  ram_add;
  logic [15:0] ram_in;
  logic        ram_write;
  logic [15:0] ram_out;
  logic        ram_ack;
  logic        load_en;
  logic        load_valid;
  logic [6:0]  load_add;
  logic [15:0] load_data;
  logic        load_ready;

  modport master (
    output ram_req, ram_add, ram_in, ram_write,
    output load_en, load_valid, load_add, load_data,
    input  ram_out, ram_ack, load_ready
  );

  modport slave (
    input  ram_req, ram_add, ram_in, ram_write,
    input  load_en, load_valid, load_add, load_data,
    output ram_out, ram_ack, load_ready
  );
endinterface

// File: rtl/hack_mem_responder.sv
// Memory-side responder for the Hack CPU: 128x16 unified store with a req/ack
// handshake, memory-mapped keyboard/LED words, a power-up clear sweep and a loader port.
module hack_mem_responder #(
  parameter int DEPTH     = 128,
  parameter int PROG_BASE = 64,
  parameter int KBD_ADDR  = 62,
  parameter int LED_ADDR  = 63
) (
  input  logic                 clk,
  input  logic                 reset,
  hack_mem_responder_if.slave  bus,
  input  logic [15:0]          kbd_in,
  output logic [15:0]          led_out,
  output logic                 prot_err,
  output logic                 busy
);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_LOAD = 3'd4;

  localparam logic [6:0] KBD_A  = 7'(KBD_ADDR);
  localparam logic [6:0] LED_A  = 7'(LED_ADDR);
  localparam logic [6:0] PROG_A = 7'(PROG_BASE);
  localparam logic [6:0] LAST_A = 7'(KBD_ADDR - 1);

  logic [2:0]  state_reg, state_next;
  logic [6:0]  ptr_reg;
  logic [6:0]  add_reg;
  logic [15:0] ram_out_reg;
  logic [15:0] led_reg;
  logic        ack_reg;
  logic        prot_reg;
  logic        busy_reg;

  logic [15:0] mem [DEPTH];

  logic        accept;
  logic        cpu_wr;
  logic        load_wr;
  logic        mem_we;
  logic [6:0]  mem_wa;
  logic [15:0] mem_wd;

  // A CPU write commits to storage on its accept edge, so a reset during the
  // following ack cycle cannot lose it.
  always_comb begin
    accept     = (state_reg == S_IDLE) && !bus.load_en && bus.ram_req && !ack_reg;
    cpu_wr     = accept && bus.ram_write;
    load_wr    = (state_reg == S_LOAD) && bus.load_en && bus.load_valid;
    state_next = state_reg;
    mem_we     = 1'b0;
    mem_wa     = bus.ram_add;
    mem_wd     = bus.ram_in;
    case (state_reg)
      S_INIT: begin
        mem_we = reset;
        mem_wa = ptr_reg;
        mem_wd = 16'h0000;
        if (ptr_reg == LAST_A) state_next = S_IDLE;
      end
      S_IDLE: begin
        if (bus.load_en)  state_next = S_LOAD;
        else if (accept)  state_next = bus.ram_write ? S_WR : S_RD;
        mem_we = cpu_wr && ((bus.ram_add < KBD_A) || (bus.ram_add == LED_A));
      end
      S_RD, S_WR: state_next = S_IDLE;
      S_LOAD: begin
        if (load_wr) begin
          mem_we = 1'b1;
          mem_wa = bus.load_add;
          mem_wd = bus.load_data;
        end
        if (!bus.load_en) state_next = S_IDLE;
      end
      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_INIT;
      ptr_reg     <= 7'd0;
      add_reg     <= 7'd0;
      ram_out_reg <= 16'h0000;
      led_reg     <= 16'h0000;
      ack_reg     <= 1'b0;
      prot_reg    <= 1'b0;
      busy_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      ack_reg   <= 1'b0;
      if (state_reg == S_INIT) begin
        ptr_reg <= ptr_reg + 7'd1;
        if (ptr_reg == LAST_A) busy_reg <= 1'b0;
      end
      if (accept) add_reg <= bus.ram_add;
      if (cpu_wr) begin
        if (bus.ram_add == LED_A)  led_reg  <= bus.ram_in;
        if (bus.ram_add >= PROG_A) prot_reg <= 1'b1;
      end
      if (load_wr && (bus.load_add == LED_A)) led_reg <= bus.load_data;
      if (state_reg == S_RD) begin
        ack_reg <= 1'b1;
        if (add_reg == KBD_A)      ram_out_reg <= kbd_in;
        else if (add_reg == LED_A) ram_out_reg <= led_reg;
        else                       ram_out_reg <= mem[add_reg];
      end
      if (state_reg == S_WR) ack_reg <= 1'b1;
    end
  end

  assign bus.ram_out    = ram_out_reg;
  assign bus.ram_ack    = ack_reg;
  assign bus.load_ready = load_wr;
  assign led_out        = led_reg;
  assign prot_err       = prot_reg;
  assign busy           = busy_reg;

endmodule

// File: tb/tb_hack_mem_responder.sv
// Directed bench for hack_mem_responder: a vector table of CPU accesses plus
// hand-written sequences for init sweep, loader, load-vs-request priority and reset.
module tb_hack_mem_responder;

  logic        clk;
  logic        reset;
  logic [15:0] kbd_in;
  logic [15:0] led_out;
  logic        prot_err;
  logic        busy;
  int          tests_run;
  int          tests_failed;

  hack_mem_responder_if bus ();

  hack_mem_responder dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .kbd_in   (kbd_in),
    .led_out  (led_out),
    .prot_err (prot_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [6:0]  add;
    logic [15:0] data;
    logic [15:0] kbd;
    logic [15:0] exp_out;
    logic [15:0] exp_led;
    logic        exp_prot;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One CPU access from a negedge; returns data, edges to ack (-1 on timeout)
  // and the ack level one cycle after the pulse.
  task automatic cpu_op(input logic wr, input logic [6:0] a, input logic [15:0] d,
                        output logic [15:0] rdata, output int lat, output logic ack_after);
    bit got;
    got   = 1'b0;
    rdata = 16'h0000;
    lat   = 0;
    @(negedge clk);
    bus.ram_req   = 1'b1;
    bus.ram_write = wr;
    bus.ram_add   = a;
    bus.ram_in    = d;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.ram_ack) begin
        got   = 1'b1;
        rdata = bus.ram_out;
      end
    end
    bus.ram_req = 1'b0;
    @(negedge clk);
    ack_after = bus.ram_ack;
    if (!got) lat = -1;
  endtask

  task automatic load_word(input logic [6:0] a, input logic [15:0] d);
    bit seen;
    seen           = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_add   = a;
    bus.load_data  = d;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.load_ready) seen = 1'b1;
    end
    if (seen) begin
      @(posedge clk);
      #1;
    end
    bus.load_valid = 1'b0;
    check("load_ready", 16'(seen), 16'd1);
    $display("[TB] load add=%0d data=%h ready=%0d", a, d, seen);
  endtask

  initial begin
    logic [15:0] rdata;
    int          lat;
    logic        ack_after;
    int          busy_cnt;
    int          cyc;
    bit          got;
    bit          ack_seen;

    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b0;
    kbd_in         = 16'h0000;
    bus.ram_req    = 1'b0;
    bus.ram_add    = 7'd0;
    bus.ram_in     = 16'h0000;
    bus.ram_write  = 1'b0;
    bus.load_en    = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_add   = 7'd0;
    bus.load_data  = 16'h0000;

    //            wr    add     data      kbd       out       led       prot
    vecs[0]  = '{1'b0, 7'd64,  16'h0000, 16'h0000, 16'h7FC0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 7'd65,  16'h0000, 16'h0000, 16'hEC10, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 7'd63,  16'hBEEF, 16'h0000, 16'hEC10, 16'hBEEF, 1'b0};
    vecs[3]  = '{1'b0, 7'd63,  16'h0000, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0};
    vecs[4]  = '{1'b1, 7'd64,  16'h1234, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b1};
    vecs[5]  = '{1'b0, 7'd64,  16'h0000, 16'h0000, 16'h7FC0, 16'hBEEF, 1'b1};
    vecs[6]  = '{1'b0, 7'd62,  16'h0000, 16'h0041, 16'h0041, 16'hBEEF, 1'b1};
    vecs[7]  = '{1'b1, 7'd62,  16'h9999, 16'h0041, 16'h0041, 16'hBEEF, 1'b1};
    vecs[8]  = '{1'b0, 7'd62,  16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 1'b1};
    vecs[9]  = '{1'b1, 7'd5,   16'hA5A5, 16'h0000, 16'h0000, 16'hBEEF, 1'b1};
    vecs[10] = '{1'b0, 7'd5,   16'h0000, 16'h0000, 16'hA5A5, 16'hBEEF, 1'b1};
    vecs[11] = '{1'b0, 7'd61,  16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 1'b1};
    vecs[12] = '{1'b1, 7'd0,   16'h0F0F, 16'h0000, 16'h0000, 16'hBEEF, 1'b1};
    vecs[13] = '{1'b0, 7'd0,   16'h0000, 16'h0000, 16'h0F0F, 16'hBEEF, 1'b1};
    vecs[14] = '{1'b1, 7'd65,  16'h5555, 16'h0000, 16'h0F0F, 16'hBEEF, 1'b1};

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    check("rst ram_out",    bus.ram_out,            16'h0000);
    check("rst ram_ack",    16'(bus.ram_ack),       16'd0);
    check("rst load_ready", 16'(bus.load_ready),    16'd0);
    check("rst led_out",    led_out,                16'h0000);
    check("rst prot_err",   16'(prot_err),          16'd0);
    check("rst busy",       16'(busy),              16'd1);

    // Init sweep: a held read of 5 is ignored for 62 cycles, then served.
    reset         = 1'b1;
    bus.ram_req   = 1'b1;
    bus.ram_write = 1'b0;
    bus.ram_add   = 7'd5;
    busy_cnt      = busy ? 1 : 0;
    got           = 1'b0;
    cyc           = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.ram_ack) got = 1'b1;
      else if (busy) busy_cnt++;
    end
    check("init ack seen",    16'(got),      16'd1);
    check("init ack cycle",   16'(cyc),      16'd64);
    check("init busy cycles", 16'(busy_cnt), 16'd62);
    check("init read 5",      bus.ram_out,   16'h0000);
    bus.ram_req = 1'b0;
    @(negedge clk);
    check("init ack pulse",   16'(bus.ram_ack), 16'd0);
    check("init busy low",    16'(busy),        16'd0);
    $display("[TB] init read add=5 out=%h ack_cycle=%0d", bus.ram_out, cyc);

    // Loader fills the program region.
    bus.load_en = 1'b1;
    load_word(7'd64, 16'h7FC0);
    load_word(7'd65, 16'hEC10);
    @(negedge clk);
    check("load_ready idle", 16'(bus.load_ready), 16'd0);
    bus.load_en = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      kbd_in = vecs[i].kbd;
      cpu_op(vecs[i].wr, vecs[i].add, vecs[i].data, rdata, lat, ack_after);
      $display("[TB] vec %0d %s add=%0d data=%h out=%h led=%h prot=%0d lat=%0d",
               i, vecs[i].wr ? "WR" : "RD", vecs[i].add, vecs[i].data,
               rdata, led_out, prot_err, lat);
      check($sformatf("vec%0d latency", i),   16'(lat),       16'd2);
      check($sformatf("vec%0d ram_out", i),   rdata,          vecs[i].exp_out);
      check($sformatf("vec%0d ack pulse", i), 16'(ack_after), 16'd0);
      check($sformatf("vec%0d led_out", i),   led_out,        vecs[i].exp_led);
      check($sformatf("vec%0d prot_err", i),  16'(prot_err),  16'(vecs[i].exp_prot));
    end

    // load_en and a read request arrive together: the loader wins.
    @(negedge clk);
    bus.load_en   = 1'b1;
    bus.ram_req   = 1'b1;
    bus.ram_write = 1'b0;
    bus.ram_add   = 7'd65;
    ack_seen      = 1'b0;
    repeat (4) begin
      @(negedge clk);
      ack_seen |= bus.ram_ack;
    end
    load_word(7'd66, 16'h2222);
    @(negedge clk);
    ack_seen |= bus.ram_ack;
    check("prio no ack during load", 16'(ack_seen), 16'd0);
    bus.load_en = 1'b0;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.ram_ack) got = 1'b1;
    end
    check("prio ack after load", 16'(got),     16'd1);
    check("prio read 65",        bus.ram_out,  16'hEC10);
    bus.ram_req = 1'b0;
    @(negedge clk);
    check("prio ack pulse", 16'(bus.ram_ack), 16'd0);
    $display("[TB] prio read add=65 out=%h after_load_cycles=%0d", bus.ram_out, cyc);
    cpu_op(1'b0, 7'd66, 16'h0000, rdata, lat, ack_after);
    check("prio loaded 66", rdata, 16'h2222);
    $display("[TB] read add=66 out=%h", rdata);

    // Reset in the RD cycle.
    @(negedge clk);
    bus.ram_req   = 1'b1;
    bus.ram_write = 1'b0;
    bus.ram_add   = 7'd64;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid rst ram_ack",  16'(bus.ram_ack), 16'd0);
    check("mid rst led_out",  led_out,          16'h0000);
    check("mid rst prot_err", 16'(prot_err),    16'd0);
    check("mid rst busy",     16'(busy),        16'd1);
    check("mid rst ram_out",  bus.ram_out,      16'h0000);
    bus.ram_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("re-init done", 16'(busy), 16'd0);
    $display("[TB] reset mid-read, re-init cycles=%0d", cyc);
    cpu_op(1'b0, 7'd64, 16'h0000, rdata, lat, ack_after);
    check("survive 64", rdata, 16'h7FC0);
    cpu_op(1'b0, 7'd65, 16'h0000, rdata, lat, ack_after);
    check("survive 65", rdata, 16'hEC10);
    cpu_op(1'b0, 7'd5, 16'h0000, rdata, lat, ack_after);
    check("recleared 5", rdata, 16'h0000);
    $display("[TB] post-reset reads done, last out=%h", rdata);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hack_mem_responder.md
Name: hack_mem_responder

Overview:
- Memory-side responder for the Hack CPU memory bus; the other end of the CPU's ram_add/ram_in/ram_write/ram_out interface.
- Holds the unified 128-word x 16-bit store:
  - 0..61 data RAM.
  - 62 keyboard input.
  - 63 LED output register.
  - 64..127 write-protected program region; the CPU fetches from 64.
- Adds a req/ack handshake, a power-up clear sweep and a loader port that fills program memory while the CPU is held off.

Parameters:
- DEPTH, 128, total words; address width is 7.
- PROG_BASE, 64, first write-protected address; also the CPU reset PC.
- KBD_ADDR, 62, memory-mapped keyboard word (read-only).
- LED_ADDR, 63, memory-mapped LED register.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-low.
- ram_req  input  1  CPU request valid; held with add/in/write until ram_ack.
- ram_add  input  7  CPU word address.
- ram_in  input  16  CPU write data.
- ram_write  input  1  1 = write, 0 = read.
- ram_out  output  16  read data; valid when ram_ack=1, held until the next read completes.
- ram_ack  output  1  one-cycle completion pulse.
- load_en  input  1  loader owns the memory; CPU requests are not accepted.
- load_valid  input  1  loader word valid.
- load_add  input  7  loader address (any, including program region).
- load_data  input  16  loader data.
- load_ready  output  1  loader word accepted this cycle.
- kbd_in  input  16  keyboard code, sampled on read of KBD_ADDR.
- led_out  output  16  LED register.
- prot_err  output  1  sticky: CPU attempted a write at address >= PROG_BASE.
- busy  output  1  high during the INIT sweep.

Behaviour:
- Async reset (reset=0):
  - ram_out=0, ram_ack=0, load_ready=0, led_out=0, prot_err=0, busy=1.
  - FSM=INIT, sweep pointer=0.
  - Storage contents are not reset.
- FSM states: INIT, IDLE, RD, WR, LOAD.
- INIT:
  - Each cycle writes 0 to address ptr, then ptr++; covers 0..61 (62 cycles).
  - After writing 61: busy=0, go to IDLE.
  - Program region, 62 and 63 are untouched. All requests are ignored (no ack); load is ignored.
- IDLE priority: load_en > ram_req.
  - load_en=1 -> LOAD.
  - Else ram_req=1 latches add/in/write; ram_write ? WR : RD.
- RD (1 cycle after accept):
  - add==62: ram_out=kbd_in sampled at this edge.
  - add==63: ram_out=led_out.
  - Else: ram_out=mem[add].
  - ram_ack=1 for exactly one cycle, then IDLE. Read latency is 2 edges from req seen to data/ack.
- WR:
  - add<62: mem[add]=data.
  - add==63: mem and led_out both updated.
  - add==62: dropped silently.
  - add>=PROG_BASE: dropped; prot_err set sticky until reset.
  - ram_ack=1 for one cycle in all cases; ram_out unchanged; then IDLE.
- ACK cycle:
  - ram_req seen high in the same cycle as ram_ack is not accepted; the CPU must drop req.
  - The earliest next accept is the cycle after ack.
- LOAD:
  - Each cycle with load_valid=1: mem[load_add]=load_data, load_ready=1 that cycle. All addresses are writable; address 63 also updates led_out.
  - load_en=0 -> IDLE. A pending ram_req waits; it is not acked.
  - load_en rising while RD/WR is in flight: the in-flight access completes and acks first.
- Address width is exactly 7; no wrap logic needed.
- Reset mid-operation: ram_ack drops immediately, the transaction is lost and INIT restarts from 0.
  - A write whose accept edge already occurred stays committed.

Test Plan:
- Release reset, hold ram_req=1 add=5 read -> busy=1 and no ack for 62 cycles; then ram_out=0x0000 with ram_ack a single-cycle pulse.
- load_en=1: load words 0x7FC0@64, 0xEC10@65 -> load_ready pulses twice. Drop load_en; CPU reads 64, 65 -> 0x7FC0, 0xEC10.
- CPU write 0xBEEF@63, then read 63 -> led_out=0xBEEF, ram_out=0xBEEF, two ack pulses. Then write 0x1234@64 -> ack, prot_err=1, read 64 still 0x7FC0.
- kbd_in=0x0041, read 62 -> ram_out=0x0041. Write 0x9999@62, read again with kbd_in=0x0000 -> 0x0000.
- Assert load_en in the same cycle as a CPU read request from IDLE -> the load wins. The read is acked only after load_en drops, with correct data.
- Pull reset low in the RD cycle -> ram_ack=0 immediately, led_out=0, prot_err=0, busy=1. Program region contents survive.
